rv_rr_arbiter: RTL and testbench
================================

Name: rv_rr_arbiter

Overview:
- Three-requester round-robin arbiter sharing one ready/valid byte stream sink, e.g. three Generator-style sources feeding a single Checker-style consumer.
- A grant is held for a burst of up to BURST_LEN beats, then re-arbitrated.
- Output goes through a one-entry registered stage, so output_port_* timing never depends combinationally on the input valids.

Parameters:
- DATA_WIDTH, 8, payload width of all data ports.
- BURST_LEN, 4, maximum beats per grant. Legal range 1..255.

Ports:
- clock_port  input  1  Single clock; all state updates on its rising edge.
- reset_port  input  1  Asynchronous, active-low reset.
- input0_data  input  DATA_WIDTH  Requester 0 payload.
- input0_valid  input  1  Requester 0 valid.
- input0_ready  output  1  Requester 0 ready.
- input1_data / input1_valid / input1_ready  Same as requester 0, for requester 1.
- input2_data / input2_valid / input2_ready  Same as requester 0, for requester 2.
- output_port_data  output  DATA_WIDTH  Registered payload to sink.
- output_port_valid  output  1  Registered valid to sink.
- output_port_ready  input  1  Sink ready.
- grant_port  output  2  Current grant index: 0..2, or 3 when no grant is held.

Behaviour:
- Reset (reset_port low, asynchronous):
  - state=IDLE, grant_port=3, last_grant=2 (so requester 0 wins the first arbitration).
  - beat_cnt=0, output_port_valid=0, output_port_data=0, all inputN_ready=0.
- Transfer definitions:
  - Input transfer on requester N: inputN_valid & inputN_ready at a rising edge.
  - Output transfer: output_port_valid & output_port_ready at a rising edge.
- Slot free: slot_free = !output_port_valid | output_port_ready. This is combinational from output_port_ready.
- inputN_ready = (state==GRANT) & (grant_port==N) & slot_free. Never high for a non-granted requester, and never high in IDLE.
- State IDLE:
  - If any inputN_valid=1, the winner is the first valid index scanning (last_grant+1) mod 3, then +2 mod 3, then last_grant.
  - At that edge: grant_port<=winner, last_grant<=winner, beat_cnt<=0, state<=GRANT.
  - If no input is valid, stay in IDLE.
- State GRANT (requester g):
  - On an input transfer: the output register loads inputg_data and output_port_valid<=1, and beat_cnt<=beat_cnt+1.
    - If beat_cnt+1==BURST_LEN: state<=IDLE, grant_port<=3.
  - If inputg_valid=0 in a GRANT cycle: no transfer, state<=IDLE, grant_port<=3. A requester dropping valid forfeits the rest of its burst.
  - If inputg_valid=1 but slot_free=0: hold state, beat_cnt unchanged.
- Output register:
  - On an output transfer with no simultaneous load, output_port_valid<=0.
  - Simultaneous output transfer and load: the new data replaces the old, valid stays 1 (full throughput, 1 beat/cycle within a burst).
  - While output_port_valid=1 and output_port_ready=0, output_port_data is stable.
- Latency:
  - First beat: input valid seen in IDLE at cycle N -> grant at N+1 -> transfer at the end of N+1 -> output_port_valid=1 in N+2.
  - Every grant handover costs exactly one IDLE bubble cycle.
- beat_cnt is 8 bits and never exceeds BURST_LEN; it cannot wrap for legal BURST_LEN.
- With BURST_LEN=1, each grant carries exactly one beat followed by one IDLE cycle.
- Mid-operation reset: everything returns to reset values immediately, and any buffered output beat is discarded.
- Input data or valid changes on non-granted requesters have no effect.

Test Plan:
- Reset: hold reset_port=0 with all valids=1 -> grant_port=3, output_port_valid=0, all readys=0. Release reset -> first grant goes to requester 0 one cycle later.
- Single requester, BURST_LEN=4: input1 streams 0x10,0x11,... with sink ready=1 -> beats out in order at 1 beat/cycle. After 4 beats, one IDLE cycle (grant_port=3), then input1 is re-granted.
- Round-robin: all three valid continuously with BURST_LEN=2, sink ready=1 -> grant sequence 0,1,2,0,... Each grant carries exactly 2 beats with tags 0xA0+n, 0xB0+n, 0xC0+n, and there are no drops or duplicates.
- Backpressure: output_port_ready=0 for 5 cycles mid-burst -> output_port_data/valid stay stable, the granted ready=0, and beat_cnt is held. After release the burst resumes with no loss.
- Early release: input2 drops valid after 1 beat with BURST_LEN=4 -> state goes to IDLE the next edge and grant_port=3. If requester 0 is waiting, it wins next.
- Async reset mid-burst: assert reset_port between clock edges -> output_port_valid and readys fall immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_rr_arbiter.sv
// Three-requester round-robin arbiter onto a single ready/valid sink.
// Grants are held for up to BURST_LEN beats; output passes through a one-entry register stage.
module rv_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic [DATA_WIDTH-1:0] input0_data,
    input  logic                  input0_valid,
    output logic                  input0_ready,
    input  logic [DATA_WIDTH-1:0] input1_data,
    input  logic                  input1_valid,
    output logic                  input1_ready,
    input  logic [DATA_WIDTH-1:0] input2_data,
    input  logic                  input2_valid,
    output logic                  input2_ready,
    output logic [DATA_WIDTH-1:0] output_port_data,
    output logic                  output_port_valid,
    input  logic                  output_port_ready,
    output logic [1:0]            grant_port
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);
    localparam logic [1:0] NO_GRANT   = 2'd3;

    state_t                  state, state_nxt;
    logic [1:0]              grant_q, grant_nxt;
    logic [1:0]              last_grant, last_nxt;
    logic [7:0]              beat_cnt, beat_nxt, beat_inc;
    logic [3:0]              valid_vec;
    logic [1:0]              scan_first, scan_second, winner;
    logic                    any_valid;
    logic                    grant_valid;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic                    slot_free;
    logic                    load;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign valid_vec = {1'b0, input2_valid, input1_valid, input0_valid};
    assign any_valid = |valid_vec;
    assign slot_free = !out_valid_q || output_port_ready;
    assign beat_inc  = beat_cnt + 8'd1;

    // Round-robin scan order: last_grant+1, last_grant+2, then last_grant itself.
    always_comb begin
        scan_first  = rr_next(last_grant);
        scan_second = rr_next(scan_first);
        if (valid_vec[scan_first])
            winner = scan_first;
        else if (valid_vec[scan_second])
            winner = scan_second;
        else
            winner = last_grant;
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        case (grant_q)
            2'd0: begin grant_valid = input0_valid; grant_data = input0_data; end
            2'd1: begin grant_valid = input1_valid; grant_data = input1_data; end
            2'd2: begin grant_valid = input2_valid; grant_data = input2_data; end
            default: begin grant_valid = 1'b0; grant_data = '0; end
        endcase
    end

    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            state      <= IDLE;
            grant_q    <= NO_GRANT;
            last_grant <= 2'd2;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_q    <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_grant;
        beat_nxt  = beat_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = GRANT;
                    grant_nxt = winner;
                    last_nxt  = winner;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                // A granted requester dropping valid forfeits the remainder of its burst.
                if (!grant_valid) begin
                    state_nxt = IDLE;
                    grant_nxt = NO_GRANT;
                end else if (slot_free) begin
                    load     = 1'b1;
                    beat_nxt = beat_inc;
                    if (beat_inc == BURST_LAST) begin
                        state_nxt = IDLE;
                        grant_nxt = NO_GRANT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = NO_GRANT;
            end
        endcase
    end

    always_comb begin
        input0_ready = (state == GRANT) && (grant_q == 2'd0) && slot_free;
        input1_ready = (state == GRANT) && (grant_q == 2'd1) && slot_free;
        input2_ready = (state == GRANT) && (grant_q == 2'd2) && slot_free;
        grant_port   = grant_q;
    end

    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
        end else if (out_valid_q && output_port_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign output_port_valid = out_valid_q;
    assign output_port_data  = out_data_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Randomized bench for rv_rr_arbiter: three instances (BURST_LEN 4, 2, 1) share stimulus,
// each tracked by a per-cycle behavioural model.
module tb_rv_rr_arbiter;

    localparam int DW = 8;
    localparam int NI = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          rst_req;
    logic [DW-1:0] d0, d1, d2;
    logic          v0, v1, v2;
    logic          out_rdy;

    logic          r0 [NI];
    logic          r1 [NI];
    logic          r2 [NI];
    logic [DW-1:0] od [NI];
    logic          ov [NI];
    logic [1:0]    gp [NI];

    int n_vec = 0;
    int n_err = 0;

    int            m_grant [NI];
    int            m_last  [NI];
    int            m_beats [NI];
    bit            m_ov    [NI];
    logic [DW-1:0] m_od    [NI];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        rv_rr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(4 >> i)) dut (
            .clock_port       (clk),
            .reset_port       (rst_n),
            .input0_data      (d0),
            .input0_valid     (v0),
            .input0_ready     (r0[i]),
            .input1_data      (d1),
            .input1_valid     (v1),
            .input1_ready     (r1[i]),
            .input2_data      (d2),
            .input2_valid     (v2),
            .input2_ready     (r2[i]),
            .output_port_data (od[i]),
            .output_port_valid(ov[i]),
            .output_port_ready(out_rdy),
            .grant_port       (gp[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_grant[i] = -1;
            m_last[i]  = 2;
            m_beats[i] = 0;
            m_ov[i]    = 1'b0;
            m_od[i]    = '0;
        end
    endtask

    task automatic drive(input int p0, input int p1, input int p2, input int pr);
        rst_n   = rst_req;
        v0      = ($urandom_range(99) < p0);
        v1      = ($urandom_range(99) < p1);
        v2      = ($urandom_range(99) < p2);
        d0      = DW'($urandom);
        d1      = DW'($urandom);
        d2      = DW'($urandom);
        out_rdy = ($urandom_range(99) < pr);
    endtask

    // Check current outputs against the model, then advance the model across one rising edge.
    task automatic step();
        logic [DW-1:0] d [3];
        bit            v [3];
        int            ng [NI];
        int            nl [NI];
        int            nb [NI];
        bit            nov [NI];
        logic [DW-1:0] nod [NI];
        #1;
        d = '{d0, d1, d2};
        v = '{v0, v1, v2};
        for (int i = 0; i < NI; i++) begin
            bit       slot;
            bit       take;
            bit [2:0] er;
            slot = !m_ov[i] || out_rdy;
            er   = '0;
            if (m_grant[i] >= 0 && slot) er[m_grant[i]] = 1'b1;
            check($sformatf("grant[%0d]", i), 32'(gp[i]), (m_grant[i] < 0) ? 32'd3 : 32'(m_grant[i]));
            check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_ov[i]));
            check($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(m_od[i]));
            check($sformatf("readys[%0d]", i), 32'({r2[i], r1[i], r0[i]}), 32'(er));

            ng[i] = m_grant[i]; nl[i] = m_last[i]; nb[i] = m_beats[i];
            nov[i] = m_ov[i]; nod[i] = m_od[i]; take = 1'b0;
            if (m_grant[i] < 0) begin
                for (int k = 1; k <= 3; k++) begin
                    int idx;
                    idx = (m_last[i] + k) % 3;
                    if (v[idx] && ng[i] < 0) begin
                        ng[i] = idx; nl[i] = idx; nb[i] = 0;
                    end
                end
            end else if (!v[m_grant[i]]) begin
                ng[i] = -1;
            end else if (slot) begin
                take   = 1'b1;
                nod[i] = d[m_grant[i]];
                nb[i]  = m_beats[i] + 1;
                if (nb[i] == (4 >> i)) ng[i] = -1;
            end
            if (take) nov[i] = 1'b1;
            else if (m_ov[i] && out_rdy) nov[i] = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            m_grant[i] = ng[i]; m_last[i] = nl[i]; m_beats[i] = nb[i];
            m_ov[i] = nov[i]; m_od[i] = nod[i];
        end
        if (!rst_n) model_reset();
    endtask

    task automatic run(input int n, input int p0, input int p1, input int p2, input int pr);
        repeat (n) begin
            @(negedge clk);
            drive(p0, p1, p2, pr);
            step();
        end
    endtask

    initial begin
        rst_req = 1'b0;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; out_rdy = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;

        // Held in reset with every requester valid.
        run(3, 100, 100, 100, 100);
        rst_req = 1'b1;
        run(12, 100, 100, 100, 100);
        // Single requester streaming into an always-ready sink.
        run(20, 0, 100, 0, 100);
        // Backpressure mid-burst.
        run(3, 100, 100, 100, 100);
        run(5, 100, 100, 100, 0);
        run(12, 100, 100, 100, 100);
        // Early release by randomly dropping valids.
        run(40, 100, 0, 50, 100);
        run(300, 60, 60, 60, 70);

        // Asynchronous reset landing between clock edges with a beat buffered.
        run(4, 100, 100, 100, 0);
        #3 rst_n = 1'b0;
        rst_req = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_valid[%0d]", i), 32'(ov[i]), 32'd0);
            check($sformatf("async_readys[%0d]", i), 32'({r2[i], r1[i], r0[i]}), 32'd0);
            check($sformatf("async_grant[%0d]", i), 32'(gp[i]), 32'd3);
        end
        model_reset();
        run(2, 100, 100, 100, 100);
        rst_req = 1'b1;
        run(150, 70, 70, 70, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
